// File: rtl/sdram_sched_pkg.sv
// Shared encodings for the SDRAM command scheduler.
package sdram_sched_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_REF  = 3'd2,
    ST_RW   = 3'd3,
    ST_DONE = 3'd4
  } sched_state_e;

  // One-hot Func_Start_Sig encodings: [2] refresh, [1] read, [0] write.
  localparam logic [2:0] FUNC_NONE = 3'b000;
  localparam logic [2:0] FUNC_REF  = 3'b100;
  localparam logic [2:0] FUNC_RD   = 3'b010;
  localparam logic [2:0] FUNC_WR   = 3'b001;

  // Refresh debt counter width.
  localparam int DEBT_W = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Round-robin channel picker: first channel with a pending read or write at or
// after the pointer, wrapping. Reports whether the winner asks for a read.
module sdram_rr_arbiter #(
  parameter int NCH = 2,
  parameter int CHW = 1
) (
  input  logic [NCH-1:0] rd_req,
  input  logic [NCH-1:0] wr_req,
  input  logic [CHW-1:0] ptr,
  output logic [CHW-1:0] win_idx,
  output logic           win_vld,
  output logic           win_rd
);

  logic [CHW-1:0] idx;

  // Scan NCH positions starting at ptr; the first requester wins, read beats write.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    win_rd  = 1'b0;
    idx     = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = CHW'((int'(ptr) + k) % NCH);
      if (!win_vld && (rd_req[idx] || wr_req[idx])) begin
        win_vld = 1'b1;
        win_idx = idx;
        win_rd  = rd_req[idx];
      end
    end
  end

endmodule

// File: rtl/sdram_sched_module.sv
// SDRAM command scheduler: power-up init handshake, round-robin client grants,
// postponable auto-refresh with a debt counter, one-hot Func_Start_Sig drive.
module sdram_sched_module
  import sdram_sched_pkg::*;
#(
  parameter  int NCH      = 2,
  parameter  int T_REF    = 1500,
  parameter  int MAX_PEND = 4,
  parameter  int REF_CLKS = 9,
  parameter  int RD_CLKS  = 8,
  parameter  int WR_CLKS  = 9,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLK,
  input  logic           RSTn,
  input  logic [NCH-1:0] RdEN_Sig,
  input  logic [NCH-1:0] WrEN_Sig,
  output logic [NCH-1:0] Done_Sig,
  output logic [CHW-1:0] Grant_Ch,
  output logic           Busy_Sig,
  output logic           Init_Start_Sig,
  input  logic           Init_Done_Sig,
  output logic [2:0]     Func_Start_Sig,
  output logic           Ref_Ovf_Sig
);

  localparam int RCW    = $clog2(T_REF);
  localparam int OP_MAX = max3(REF_CLKS, RD_CLKS, WR_CLKS);
  localparam int OPW    = $clog2(OP_MAX + 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_PEND);

  sched_state_e      state_q, state_d;
  logic [RCW-1:0]    ref_cnt_q, ref_cnt_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic [CHW-1:0]    ptr_q, ptr_d;
  logic [OPW-1:0]    op_cnt_q, op_cnt_d;
  logic [CHW-1:0]    grant_q, grant_d;
  logic [2:0]        func_q, func_d;
  logic [NCH-1:0]    done_q, done_d;
  logic              busy_q, busy_d;
  logic              init_start_q, init_start_d;
  logic              ovf_q, ovf_d;

  logic              wrap;
  logic              issue;
  logic [CHW-1:0]    win_idx;
  logic              win_vld;
  logic              win_rd;

  sdram_rr_arbiter #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .rd_req  (RdEN_Sig),
    .wr_req  (WrEN_Sig),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .win_vld (win_vld),
    .win_rd  (win_rd)
  );

  // Next-state logic: FSM, refresh timer, debt bookkeeping and registered outputs.
  always_comb begin
    state_d      = state_q;
    ref_cnt_d    = ref_cnt_q;
    debt_d       = debt_q;
    ptr_d        = ptr_q;
    op_cnt_d     = op_cnt_q;
    grant_d      = grant_q;
    func_d       = func_q;
    done_d       = '0;
    busy_d       = busy_q;
    init_start_d = init_start_q;
    ovf_d        = ovf_q;
    issue        = 1'b0;

    // Refresh timer runs everywhere except INIT.
    wrap = (state_q != ST_INIT) && (ref_cnt_q == RCW'(T_REF - 1));
    if (state_q != ST_INIT) begin
      ref_cnt_d = wrap ? '0 : ref_cnt_q + 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        if (Init_Done_Sig) begin
          init_start_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          init_start_d = 1'b1;
        end
      end

      ST_IDLE: begin
        // Saturated debt beats clients; clients beat ordinary postponed refresh.
        if (debt_q == DEBT_MAX) begin
          issue = 1'b1;
        end else if (win_vld) begin
          state_d  = ST_RW;
          busy_d   = 1'b1;
          grant_d  = win_idx;
          func_d   = win_rd ? FUNC_RD : FUNC_WR;
          op_cnt_d = win_rd ? OPW'(RD_CLKS - 1) : OPW'(WR_CLKS - 1);
          ptr_d    = (win_idx == CHW'(NCH - 1)) ? '0 : win_idx + 1'b1;
        end else if (debt_q != '0) begin
          issue = 1'b1;
        end
        if (issue) begin
          state_d  = ST_REF;
          busy_d   = 1'b1;
          func_d   = FUNC_REF;
          op_cnt_d = OPW'(REF_CLKS - 1);
        end
      end

      ST_REF, ST_RW: begin
        if (op_cnt_q == '0) begin
          func_d  = FUNC_NONE;
          state_d = ST_DONE;
          if (state_q == ST_RW) done_d[grant_q] = 1'b1;
        end else begin
          op_cnt_d = op_cnt_q - 1'b1;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_INIT;
    endcase

    // A wrap and an issue in the same cycle cancel out.
    if (wrap && !issue) begin
      if (debt_q != DEBT_MAX) debt_d = debt_q + 1'b1;
    end else if (!wrap && issue) begin
      debt_d = debt_q - 1'b1;
    end

    if (wrap && (debt_q == DEBT_MAX)) ovf_d = 1'b1;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= ST_INIT;
      ref_cnt_q    <= '0;
      debt_q       <= '0;
      ptr_q        <= '0;
      op_cnt_q     <= '0;
      grant_q      <= '0;
      func_q       <= FUNC_NONE;
      done_q       <= '0;
      busy_q       <= 1'b1;
      init_start_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_cnt_q    <= ref_cnt_d;
      debt_q       <= debt_d;
      ptr_q        <= ptr_d;
      op_cnt_q     <= op_cnt_d;
      grant_q      <= grant_d;
      func_q       <= func_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      init_start_q <= init_start_d;
      ovf_q        <= ovf_d;
    end
  end

  assign Done_Sig       = done_q;
  assign Grant_Ch       = grant_q;
  assign Busy_Sig       = busy_q;
  assign Init_Start_Sig = init_start_q;
  assign Func_Start_Sig = func_q;
  assign Ref_Ovf_Sig    = ovf_q;

endmodule

// File: tb/tb_sdram_sched_module.sv
// Directed bench for sdram_sched_module at default parameters.
module tb_sdram_sched_module;

  localparam int NCH = 2;
  localparam int CHW = 1;

  logic           CLK;
  logic           RSTn;
  logic [NCH-1:0] RdEN_Sig;
  logic [NCH-1:0] WrEN_Sig;
  logic [NCH-1:0] Done_Sig;
  logic [CHW-1:0] Grant_Ch;
  logic           Busy_Sig;
  logic           Init_Start_Sig;
  logic           Init_Done_Sig;
  logic [2:0]     Func_Start_Sig;
  logic           Ref_Ovf_Sig;

  int tests;
  int fails;
  int cyc;

  sdram_sched_module #(
    .NCH(2), .T_REF(1500), .MAX_PEND(4), .REF_CLKS(9), .RD_CLKS(8), .WR_CLKS(9)
  ) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .RdEN_Sig       (RdEN_Sig),
    .WrEN_Sig       (WrEN_Sig),
    .Done_Sig       (Done_Sig),
    .Grant_Ch       (Grant_Ch),
    .Busy_Sig       (Busy_Sig),
    .Init_Start_Sig (Init_Start_Sig),
    .Init_Done_Sig  (Init_Done_Sig),
    .Func_Start_Sig (Func_Start_Sig),
    .Ref_Ovf_Sig    (Ref_Ovf_Sig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Wait for the next op and observe it: function code, grant, hold length,
  // start cycle, Done_Sig and Func_Start_Sig in the cycle after the hold.
  task automatic run_op(output logic [2:0] f, output logic [CHW-1:0] g,
                        output int len, output logic [NCH-1:0] dn,
                        output int start, output logic [2:0] fend, output bit to);
    int n;
    n = 0; to = 1'b0; f = '0; g = '0; len = 0; dn = '0; start = 0; fend = '0;
    while (Func_Start_Sig == 3'b000 && n < 4000) begin
      tick();
      n++;
    end
    if (Func_Start_Sig == 3'b000) begin
      to = 1'b1;
      return;
    end
    f = Func_Start_Sig;
    g = Grant_Ch;
    start = cyc;
    len = 1;
    tick();
    while (Func_Start_Sig == f && len < 64) begin
      len++;
      tick();
    end
    dn = Done_Sig;
    fend = Func_Start_Sig;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; RdEN_Sig = '0; WrEN_Sig = '0; Init_Done_Sig = 1'b0;
    #22;
    tests++; if (Busy_Sig !== 1'b1) begin fails++; $display("FAIL rst_busy got %b want 1", Busy_Sig); end
    tests++; if (Init_Start_Sig !== 1'b0) begin fails++; $display("FAIL rst_init_start got %b want 0", Init_Start_Sig); end
    tests++; if (Func_Start_Sig !== 3'b000) begin fails++; $display("FAIL rst_func got %b want 000", Func_Start_Sig); end
    tests++; if (Done_Sig !== 2'b00) begin fails++; $display("FAIL rst_done got %b want 00", Done_Sig); end
    tests++; if (Grant_Ch !== 1'b0) begin fails++; $display("FAIL rst_grant got %0d want 0", Grant_Ch); end
    tests++; if (Ref_Ovf_Sig !== 1'b0) begin fails++; $display("FAIL rst_ovf got %b want 0", Ref_Ovf_Sig); end
    RSTn = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      tests++;
      if (Init_Start_Sig !== 1'b1 || Busy_Sig !== 1'b1) begin
        fails++; $display("FAIL init_wait cyc %0d start/busy got %b%b want 11", c, Init_Start_Sig, Busy_Sig);
      end
    end
    Init_Done_Sig = 1'b1;
    tick();
    Init_Done_Sig = 1'b0;
    tests++; if (Init_Start_Sig !== 1'b0) begin fails++; $display("FAIL init_end_start got %b want 0", Init_Start_Sig); end
    tests++; if (Busy_Sig !== 1'b0) begin fails++; $display("FAIL init_end_busy got %b want 0", Busy_Sig); end
  endtask

  task automatic test_alternate();
    logic [2:0] f, fend; logic [CHW-1:0] g; logic [NCH-1:0] dn; int len, st; bit to;
    logic [CHW-1:0] eg; logic [2:0] ef; int el; logic [NCH-1:0] ed;
    RdEN_Sig[0] = 1'b1;
    WrEN_Sig[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(f, g, len, dn, st, fend, to);
      if (i == 3) begin RdEN_Sig = '0; WrEN_Sig = '0; end
      eg = CHW'(i % 2);
      ef = (i % 2 == 0) ? 3'b010 : 3'b001;
      el = (i % 2 == 0) ? 8 : 9;
      ed = (i % 2 == 0) ? 2'b01 : 2'b10;
      tests++; if (to) begin fails++; $display("FAIL alt_timeout op %0d", i); end
      tests++; if (g !== eg) begin fails++; $display("FAIL alt_grant op %0d got %0d want %0d", i, g, eg); end
      tests++; if (f !== ef) begin fails++; $display("FAIL alt_func op %0d got %b want %b", i, f, ef); end
      tests++; if (len !== el) begin fails++; $display("FAIL alt_len op %0d got %0d want %0d", i, len, el); end
      tests++; if (dn !== ed || fend !== 3'b000) begin
        fails++; $display("FAIL alt_done op %0d done %b func %b want %b 000", i, dn, fend, ed);
      end
    end
    tick();
    tests++; if (Busy_Sig !== 1'b0 || Done_Sig !== 2'b00) begin
      fails++; $display("FAIL alt_idle busy %b done %b want 0 00", Busy_Sig, Done_Sig);
    end
  endtask

  task automatic test_single_read();
    RdEN_Sig[0] = 1'b1;
    tick();
    tests++; if (Func_Start_Sig !== 3'b010 || Grant_Ch !== 1'b0 || Busy_Sig !== 1'b1) begin
      fails++; $display("FAIL rd_start func %b grant %0d busy %b want 010 0 1", Func_Start_Sig, Grant_Ch, Busy_Sig);
    end
    for (int k = 1; k < 8; k++) begin
      tick();
      tests++; if (Func_Start_Sig !== 3'b010 || Done_Sig !== 2'b00) begin
        fails++; $display("FAIL rd_hold cyc %0d func %b done %b want 010 00", k, Func_Start_Sig, Done_Sig);
      end
    end
    tick();
    tests++; if (Func_Start_Sig !== 3'b000 || Done_Sig !== 2'b01) begin
      fails++; $display("FAIL rd_done func %b done %b want 000 01", Func_Start_Sig, Done_Sig);
    end
    RdEN_Sig = '0;
    tick();
    tests++; if (Done_Sig !== 2'b00 || Busy_Sig !== 1'b0) begin
      fails++; $display("FAIL rd_idle done %b busy %b want 00 0", Done_Sig, Busy_Sig);
    end
  endtask

  task automatic test_refresh();
    logic [2:0] f, fend; logic [CHW-1:0] g; logic [NCH-1:0] dn; int len, st; bit to;
    int exp_start [2];
    exp_start[0] = 1523;
    exp_start[1] = 3023;
    for (int i = 0; i < 2; i++) begin
      run_op(f, g, len, dn, st, fend, to);
      tests++; if (to) begin fails++; $display("FAIL ref_timeout %0d", i); end
      tests++; if (f !== 3'b100 || len !== 9) begin
        fails++; $display("FAIL ref_op %0d func %b len %0d want 100 9", i, f, len);
      end
      tests++; if (st !== exp_start[i]) begin
        fails++; $display("FAIL ref_start %0d got cyc %0d want %0d", i, st, exp_start[i]);
      end
      tests++; if (dn !== 2'b00 || fend !== 3'b000) begin
        fails++; $display("FAIL ref_nodone %0d done %b func %b want 00 000", i, dn, fend);
      end
    end
  endtask

  task automatic test_postpone();
    logic [2:0] f, fend; logic [CHW-1:0] g; logic [NCH-1:0] dn; int len, st; bit to;
    int ops;
    RdEN_Sig[0] = 1'b1;
    WrEN_Sig[1] = 1'b1;
    ops = 0;
    f = '0; to = 1'b0;
    while (ops < 1200 && !to && f !== 3'b100) begin
      run_op(f, g, len, dn, st, fend, to);
      ops++;
    end
    tests++; if (to || f !== 3'b100) begin fails++; $display("FAIL post_found func %b want 100", f); end
    tests++; if (st < 9023 || st > 9033) begin
      fails++; $display("FAIL post_start got cyc %0d want 9023..9033", st);
    end
    tests++; if (len !== 9 || dn !== 2'b00) begin
      fails++; $display("FAIL post_ref len %0d done %b want 9 00", len, dn);
    end
    tests++; if (Ref_Ovf_Sig !== 1'b0) begin fails++; $display("FAIL post_ovf got %b want 0", Ref_Ovf_Sig); end
    run_op(f, g, len, dn, st, fend, to);
    RdEN_Sig = '0;
    WrEN_Sig = '0;
    tests++; if (to || f == 3'b100 || f == 3'b000) begin
      fails++; $display("FAIL post_rw_after got %b want 010 or 001", f);
    end
    for (int i = 0; i < 3; i++) begin
      run_op(f, g, len, dn, st, fend, to);
      tests++; if (to || f !== 3'b100 || len !== 9) begin
        fails++; $display("FAIL post_drain %0d func %b len %0d want 100 9", i, f, len);
      end
    end
    tick();
    tick();
    tests++; if (Func_Start_Sig !== 3'b000 || Busy_Sig !== 1'b0 || Ref_Ovf_Sig !== 1'b0) begin
      fails++; $display("FAIL post_idle func %b busy %b ovf %b want 000 0 0", Func_Start_Sig, Busy_Sig, Ref_Ovf_Sig);
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    WrEN_Sig[0] = 1'b1;
    n = 0;
    while (Func_Start_Sig !== 3'b001 && n < 50) begin
      tick();
      n++;
    end
    tests++; if (Func_Start_Sig !== 3'b001) begin fails++; $display("FAIL mid_wr_start got %b want 001", Func_Start_Sig); end
    tick(); tick(); tick();
    #3;
    RSTn = 1'b0;
    #1;
    tests++; if (Func_Start_Sig !== 3'b000 || Done_Sig !== 2'b00) begin
      fails++; $display("FAIL mid_rst_now func %b done %b want 000 00", Func_Start_Sig, Done_Sig);
    end
    tests++; if (Busy_Sig !== 1'b1 || Init_Start_Sig !== 1'b0 || Grant_Ch !== 1'b0) begin
      fails++; $display("FAIL mid_rst_outs busy %b init %b grant %0d want 1 0 0", Busy_Sig, Init_Start_Sig, Grant_Ch);
    end
    WrEN_Sig = '0;
    tick();
    tick();
    tests++; if (Done_Sig !== 2'b00 || Func_Start_Sig !== 3'b000) begin
      fails++; $display("FAIL mid_rst_hold done %b func %b want 00 000", Done_Sig, Func_Start_Sig);
    end
    RSTn = 1'b1;
    tick();
    tests++; if (Init_Start_Sig !== 1'b1 || Busy_Sig !== 1'b1 || Done_Sig !== 2'b00) begin
      fails++; $display("FAIL mid_rst_restart init %b busy %b done %b want 1 1 00", Init_Start_Sig, Busy_Sig, Done_Sig);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    test_reset();
    test_alternate();
    test_single_read();
    test_refresh();
    test_postpone();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
